// File: rtl/cpu_axi_arbiter.sv
// cpu_axi_arbiter: shares one single-beat AXI master port between the
// instruction-fetch and data-memory requesters of the no-cache pipeline.
// One transaction in flight at a time; round-robin grant, data first after reset.
module cpu_axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // instruction-fetch requester
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  // data-memory requester
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W/8-1:0] data_wstrb,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  // AXI read channels
  output logic [ADDR_W-1:0]   araddr,
  output logic [2:0]          arsize,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                rvalid,
  output logic                rready,
  // AXI write channels
  output logic [ADDR_W-1:0]   awaddr,
  output logic [2:0]          awsize,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic                bvalid,
  output logic                bready
);

  localparam int STRB_W = DATA_W / 8;

  // requester identity: also the encoding of last_grant / owner
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t              state;
  state_t              state_next;

  // The owner of the in-flight transaction is always the most recent grant,
  // so a single register serves as both last_grant and owner.
  logic                last_grant;
  logic                owner;
  logic                wr_lat;
  logic [ADDR_W-1:0]   addr_lat;
  logic [1:0]          size_lat;
  logic [DATA_W-1:0]   wdata_lat;
  logic [STRB_W-1:0]   wstrb_lat;
  logic                aw_done;
  logic                w_done;

  logic                grant_data;
  logic                grant_fire;
  logic                aw_hs;
  logic                w_hs;
  logic                wr_complete;
  logic                addr_ok;
  logic                data_ok;

  assign owner = last_grant;

  // Round-robin pick and write-channel handshake decode
  always_comb begin
    // a lone request wins; on a tie the requester not granted last time wins
    grant_data  = data_req & (~inst_req | (last_grant == OWN_INST));
    grant_fire  = (state == IDLE) & (inst_req | data_req);
    aw_hs       = (state == WR_ADDR) & ~aw_done & awready;
    w_hs        = (state == WR_ADDR) & ~w_done & wready;
    // both halves of the write request done, now or in an earlier cycle
    wr_complete = (aw_done | aw_hs) & (w_done | w_hs);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decision
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_fire) begin
          state_next = (grant_data && data_wr) ? WR_ADDR : RD_ADDR;
        end
      end
      RD_ADDR: if (arready)     state_next = RD_DATA;
      RD_DATA: if (rvalid)      state_next = IDLE;
      WR_ADDR: if (wr_complete) state_next = WR_RESP;
      WR_RESP: if (bvalid)      state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // Latch the granted request so later requester changes cannot leak onto the bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= OWN_INST;
      wr_lat     <= 1'b0;
      addr_lat   <= '0;
      size_lat   <= '0;
      wdata_lat  <= '0;
      wstrb_lat  <= '0;
    end else if (grant_fire) begin
      last_grant <= grant_data ? OWN_DATA : OWN_INST;
      if (grant_data) begin
        wr_lat    <= data_wr;
        addr_lat  <= data_addr;
        size_lat  <= data_size;
        wdata_lat <= data_wdata;
        wstrb_lat <= data_wstrb;
      end else begin
        // fetches are always full-word reads
        wr_lat    <= 1'b0;
        addr_lat  <= inst_addr;
        size_lat  <= 2'd2;
        wdata_lat <= '0;
        wstrb_lat <= '0;
      end
    end
  end

  // Track AW and W completion separately since the slave may accept them in any order
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (grant_fire) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

  // Bus and requester outputs, decoded from the registered state
  always_comb begin
    arvalid = 1'b0;
    rready  = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    addr_ok = 1'b0;
    data_ok = 1'b0;
    case (state)
      RD_ADDR: begin
        arvalid = 1'b1;
        addr_ok = arready;
      end
      RD_DATA: begin
        rready  = 1'b1;
        data_ok = rvalid;
      end
      WR_ADDR: begin
        awvalid = ~aw_done;
        wvalid  = ~w_done;
        addr_ok = wr_complete;
      end
      WR_RESP: begin
        bready  = 1'b1;
        data_ok = bvalid;
      end
      default: begin
        addr_ok = 1'b0;
      end
    endcase

    araddr = addr_lat;
    awaddr = addr_lat;
    arsize = {1'b0, size_lat};
    awsize = {1'b0, size_lat};
    wdata  = wdata_lat;
    wstrb  = wstrb_lat;

    // only the owner ever sees an ok pulse
    inst_addr_ok = addr_ok & (owner == OWN_INST);
    inst_data_ok = data_ok & (owner == OWN_INST);
    data_addr_ok = addr_ok & (owner == OWN_DATA);
    data_data_ok = data_ok & (owner == OWN_DATA);

    inst_rdata = '0;
    data_rdata = '0;
    if ((state == RD_DATA) && rvalid) begin
      if (owner == OWN_INST) begin
        inst_rdata = rdata;
      end else if (!wr_lat) begin
        data_rdata = rdata;
      end
    end
  end

endmodule

// File: tb/tb_cpu_axi_arbiter.sv
// Testbench for cpu_axi_arbiter: directed scenarios followed by random traffic,
// all checked every cycle against a transaction-level reference model.
module tb_cpu_axi_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  cpu_axi_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one transaction record, who it belongs to, and which half is done
  bit          m_busy;
  bit          m_phase;   // 0: request not yet accepted, 1: waiting for data/response
  bit          m_owner;   // 0 = fetch, 1 = data
  bit          m_last;    // requester granted most recently
  bit          m_wr;
  bit          m_aw;
  bit          m_w;
  logic [31:0] m_addr;
  logic [1:0]  m_size;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;

  bit e_arv, e_awv, e_wv, e_rr, e_br;
  bit e_addr_done, e_resp_done;
  bit e_iaok, e_daok, e_idok, e_ddok;

  int grant_log[$];  // owners as seen on the DUT's addr_ok outputs (0 fetch, 1 data)

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Let combinational outputs settle, then compare every output with the model
  task automatic settle();
    #1;
    if (inst_addr_ok === 1'b1) grant_log.push_back(0);
    if (data_addr_ok === 1'b1) grant_log.push_back(1);
    if (rst) begin
      {e_arv, e_awv, e_wv, e_rr, e_br} = '0;
      {e_addr_done, e_resp_done, e_iaok, e_daok, e_idok, e_ddok} = '0;
      chk("rst_ctrl", {23'd0, arvalid, awvalid, wvalid, rready, bready,
                       inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 32'd0);
      chk("rst_araddr", araddr, 32'd0);
      chk("rst_awaddr", awaddr, 32'd0);
      chk("rst_wdata", wdata, 32'd0);
      chk("rst_sizes", {26'd0, arsize, awsize}, 32'd0);
      chk("rst_irdata", inst_rdata, 32'd0);
      chk("rst_drdata", data_rdata, 32'd0);
    end else begin
      e_arv = m_busy && !m_phase && !m_wr;
      e_awv = m_busy && !m_phase && m_wr && !m_aw;
      e_wv  = m_busy && !m_phase && m_wr && !m_w;
      e_rr  = m_busy && m_phase && !m_wr;
      e_br  = m_busy && m_phase && m_wr;
      e_addr_done = m_busy && !m_phase &&
                    (m_wr ? ((m_aw || awready) && (m_w || wready)) : arready);
      e_resp_done = m_busy && m_phase && (m_wr ? bvalid : rvalid);
      e_iaok = e_addr_done && !m_owner;
      e_daok = e_addr_done && m_owner;
      e_idok = e_resp_done && !m_owner;
      e_ddok = e_resp_done && m_owner;
      chk("arvalid", arvalid, e_arv);
      chk("awvalid", awvalid, e_awv);
      chk("wvalid", wvalid, e_wv);
      chk("rready", rready, e_rr);
      chk("bready", bready, e_br);
      chk("inst_addr_ok", inst_addr_ok, e_iaok);
      chk("data_addr_ok", data_addr_ok, e_daok);
      chk("inst_data_ok", inst_data_ok, e_idok);
      chk("data_data_ok", data_data_ok, e_ddok);
      if (e_arv) begin
        chk("araddr", araddr, m_addr);
        chk("arsize", arsize, {1'b0, m_size});
      end
      if (e_awv) begin
        chk("awaddr", awaddr, m_addr);
        chk("awsize", awsize, {1'b0, m_size});
      end
      if (e_wv) begin
        chk("wdata", wdata, m_wdata);
        chk("wstrb", wstrb, m_wstrb);
      end
      if (e_idok) chk("inst_rdata", inst_rdata, rdata);
      if (e_ddok && !m_wr) chk("data_rdata", data_rdata, rdata);
    end
  endtask

  // Advance the model across the clock edge, then let requesters drop accepted requests
  task automatic advance();
    bit own;
    if (rst) begin
      m_busy = 0;
      m_last = 0;
    end else if (!m_busy) begin
      if (inst_req || data_req) begin
        own = (inst_req && data_req) ? !m_last : data_req;
        m_owner = own;
        m_last  = own;
        m_busy  = 1;
        m_phase = 0;
        m_aw    = 0;
        m_w     = 0;
        if (own) begin
          m_wr = data_wr; m_addr = data_addr; m_size = data_size;
          m_wdata = data_wdata; m_wstrb = data_wstrb;
        end else begin
          m_wr = 0; m_addr = inst_addr; m_size = 2'd2;
        end
      end
    end else begin
      if (!m_phase && m_wr) begin
        if (awready) m_aw = 1;
        if (wready)  m_w  = 1;
      end
      if (e_addr_done) m_phase = 1;
      if (e_resp_done) m_busy = 0;
    end
    @(posedge clk);
    #1;
    if (!rst) begin
      if (e_iaok) inst_req = 1'b0;
      if (e_daok) data_req = 1'b0;
    end
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  // Run the slave with all readies high until nothing is outstanding
  task automatic drain();
    int i;
    for (i = 0; i < 40; i++) begin
      if (!m_busy && !inst_req && !data_req) break;
      arready = 1; awready = 1; wready = 1;
      rvalid = m_busy && m_phase && !m_wr;
      bvalid = m_busy && m_phase && m_wr;
      step();
    end
    chk("drain_bound", {31'd0, m_busy}, 32'd0);
    arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
  endtask

  initial begin
    rst = 1; inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_size = 0;
    data_addr = 0; data_wdata = 0; data_wstrb = 0; arready = 0; rdata = 0; rvalid = 0;
    awready = 0; wready = 0; bvalid = 0;
    m_busy = 0; m_phase = 0; m_owner = 0; m_last = 0; m_wr = 0; m_aw = 0; m_w = 0;
    m_addr = 0; m_size = 0; m_wdata = 0; m_wstrb = 0;
    @(posedge clk);
    #1;
    // reset state
    step();
    step();
    rst = 0;

    // fetch only, immediate slave
    inst_req = 1; inst_addr = 32'hBFC0_0000; arready = 1; rvalid = 1; rdata = 32'h3C1D_0000;
    settle(); chk("t1_c0_arvalid", arvalid, 1'b0); advance();
    settle(); chk("t1_c1_arvalid", arvalid, 1'b1); chk("t1_c1_iaok", inst_addr_ok, 1'b1); advance();
    settle(); chk("t1_c2_idok", inst_data_ok, 1'b1); chk("t1_c2_rdata", inst_rdata, 32'h3C1D_0000); advance();
    settle(); chk("t1_c3_idok", inst_data_ok, 1'b0); advance();
    rvalid = 0; arready = 0;

    // both requesting at reset exit: data first, then strict alternation
    rst = 1; step(); rst = 0;
    grant_log.delete();
    arready = 1; rvalid = 1; rdata = 32'h1234_5678;
    for (int i = 0; i < 40 && grant_log.size() < 4; i++) begin
      inst_req = 1; inst_addr = 32'hBFC0_0004;
      data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h8000_1000;
      step();
    end
    chk("t2_count", grant_log.size(), 32'd4);
    if (grant_log.size() >= 4) begin
      chk("t2_grant0", grant_log[0], 32'd1);
      chk("t2_grant1", grant_log[1], 32'd0);
      chk("t2_grant2", grant_log[2], 32'd1);
      chk("t2_grant3", grant_log[3], 32'd0);
    end
    inst_req = 0; data_req = 0;
    drain();

    // byte store, W accepted three cycles before AW, response after two cycles
    data_req = 1; data_wr = 1; data_size = 0; data_addr = 32'h8000_0003;
    data_wdata = 32'h1122_3344; data_wstrb = 4'b1000;
    step();
    wready = 1;
    settle(); chk("t3_c1_daok", data_addr_ok, 1'b0); chk("t3_awsize", awsize, 3'd0);
    chk("t3_wstrb", wstrb, 4'b1000); advance();
    wready = 0;
    settle(); chk("t3_c2_wvalid", wvalid, 1'b0); chk("t3_c2_daok", data_addr_ok, 1'b0); advance();
    settle(); chk("t3_c3_daok", data_addr_ok, 1'b0); advance();
    awready = 1;
    settle(); chk("t3_c4_daok", data_addr_ok, 1'b1); advance();
    awready = 0;
    settle(); chk("t3_c5_ddok", data_data_ok, 1'b0); advance();
    settle(); chk("t3_c6_ddok", data_data_ok, 1'b0); advance();
    bvalid = 1;
    settle(); chk("t3_c7_ddok", data_data_ok, 1'b1); advance();
    bvalid = 0;
    settle(); chk("t3_c8_ddok", data_data_ok, 1'b0); advance();
    data_wr = 0;

    // load with a slow read response while a fetch waits
    data_req = 1; data_size = 2; data_addr = 32'h8000_2000; arready = 1;
    step();
    inst_req = 1; inst_addr = 32'hBFC0_0010;
    settle(); chk("t4_c1_daok", data_addr_ok, 1'b1); advance();
    for (int i = 0; i < 5; i++) begin
      settle(); chk("t4_wait_iaok", inst_addr_ok, 1'b0); advance();
    end
    rvalid = 1; rdata = 32'hCAFE_F00D;
    settle(); chk("t4_ddok", data_data_ok, 1'b1); chk("t4_drdata", data_rdata, 32'hCAFE_F00D);
    chk("t4_iaok_held", inst_addr_ok, 1'b0); advance();
    rvalid = 0;
    settle(); chk("t4_idle_arvalid", arvalid, 1'b0); advance();
    settle(); chk("t4_fetch_iaok", inst_addr_ok, 1'b1); chk("t4_fetch_araddr", araddr, 32'hBFC0_0010); advance();
    drain();

    // fetch address changes after the grant
    inst_req = 1; inst_addr = 32'hBFC0_0020;
    step();
    inst_addr = 32'h1234_0000;
    settle(); chk("t5_c1_araddr", araddr, 32'hBFC0_0020); advance();
    settle(); chk("t5_c2_araddr", araddr, 32'hBFC0_0020); advance();
    arready = 1;
    settle(); chk("t5_c3_iaok", inst_addr_ok, 1'b1); chk("t5_c3_araddr", araddr, 32'hBFC0_0020); advance();
    drain();

    // reset during RD_DATA aborts silently and restores the data-first tie-break
    inst_req = 1; inst_addr = 32'hBFC0_0030; arready = 1;
    step();
    step();
    rst = 1; rvalid = 1; rdata = 32'hDEAD_BEEF;
    settle(); chk("t6_idok", inst_data_ok, 1'b0); chk("t6_rready", rready, 1'b0); advance();
    rst = 0; rvalid = 0; inst_req = 0;
    settle(); chk("t6_idle_arvalid", arvalid, 1'b0); advance();
    inst_req = 1; inst_addr = 32'hBFC0_0040;
    data_req = 1; data_wr = 0; data_size = 1; data_addr = 32'h8000_3002;
    step();
    settle(); chk("t6_data_first", data_addr_ok, 1'b1); chk("t6_fetch_waits", inst_addr_ok, 1'b0);
    chk("t6_arsize", arsize, 3'd1); advance();
    drain();

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if (!inst_req && $urandom_range(0, 3) == 0) begin
        inst_req = 1; inst_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!data_req && $urandom_range(0, 3) == 0) begin
        data_req = 1; data_wr = 1'($urandom_range(0, 1)); data_size = 2'($urandom_range(0, 2));
        data_addr = $urandom; data_wdata = $urandom; data_wstrb = 4'($urandom);
      end
      arready = 1'($urandom_range(0, 1));
      awready = 1'($urandom_range(0, 1));
      wready  = 1'($urandom_range(0, 1));
      rdata   = $urandom;
      rvalid  = (m_busy && m_phase && !m_wr) ? 1'($urandom_range(0, 1)) : 1'b0;
      bvalid  = (m_busy && m_phase && m_wr)  ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
    end
    inst_req = 0; data_req = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_axi_arbiter.md
Name: cpu_axi_arbiter

Overview:
- Shares one single-beat AXI master port between the instruction-fetch and data-memory requesters of the no-cache pipeline.
- Each requester uses an SRAM-like req/addr_ok/data_ok handshake. The pipeline stall logic derives inst_stall_F and data_stall_M from these handshakes.
- Only one transaction is in flight at a time. Arbitration is round-robin with data favoured after reset.

Parameters:
- ADDR_W, 32, address width of requesters and bus.
- DATA_W, 32, data width (wstrb width is DATA_W/8).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
inst_req  in  1  fetch request, held until inst_addr_ok
inst_addr  in  ADDR_W  fetch address (word read)
inst_addr_ok  out  1  fetch request accepted by bus
inst_data_ok  out  1  fetch data valid
inst_rdata  out  DATA_W  fetch data
data_req  in  1  data request, held until data_addr_ok
data_wr  in  1  1=store, 0=load
data_size  in  2  0=byte, 1=half, 2=word
data_addr  in  ADDR_W  data address
data_wdata  in  DATA_W  store data
data_wstrb  in  DATA_W/8  store byte enables
data_addr_ok  out  1  data request accepted
data_data_ok  out  1  load data valid / store response received
data_rdata  out  DATA_W  load data
araddr  out  ADDR_W  AXI read address
arsize  out  3  AXI read size
arvalid  out  1  AXI read address valid
arready  in  1  AXI read address ready
rdata  in  DATA_W  AXI read data
rvalid  in  1  AXI read data valid
rready  out  1  AXI read data ready
awaddr  out  ADDR_W  AXI write address
awsize  out  3  AXI write size
awvalid  out  1  AXI write address valid
awready  in  1  AXI write address ready
wdata  out  DATA_W  AXI write data
wstrb  out  DATA_W/8  AXI write strobes
wvalid  out  1  AXI write data valid
wready  in  1  AXI write data ready
bvalid  in  1  AXI write response valid
bready  out  1  AXI write response ready

Behaviour:
- Reset: state=IDLE and last_grant=INST. All valids, readies and ok outputs are 0. Address, data and size registers are 0. Reset asserted mid-transaction aborts at once with no ok pulse.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP.
- IDLE, grant decision:
  - Only one request pending: grant it.
  - Both pending: grant the one not equal to last_grant.
  - Grant action: latch addr, size, wdata, wstrb, wr and owner; update last_grant.
  - Next state: WR_ADDR for a data store, else RD_ADDR.
  - Fetch size is fixed at 2. arsize/awsize = {1'b0, size}.
- RD_ADDR: arvalid=1 (registered). On arvalid&arready: pulse owner addr_ok combinationally in the same cycle, then go to RD_DATA.
- RD_DATA: rready=1. On rvalid: pulse owner data_ok in the same cycle, drive owner rdata from the bus rdata, then go to IDLE.
- WR_ADDR: awvalid and wvalid are asserted independently.
  - Each drops after its own handshake; flags aw_done and w_done record completion.
  - When both are complete (including both in the same cycle), pulse data_addr_ok in that cycle and go to WR_RESP.
- WR_RESP: bready=1. On bvalid: pulse data_data_ok and go to IDLE.
- The non-owner's ok signals stay 0. A non-owner request waits, held by the requester, and is never dropped.
- Latched fields are immune to requester input changes after the grant.
- Minimum read latency: req seen in IDLE at cycle 0 → arvalid at cycle 1 → data_ok no earlier than cycle 2.
- A new grant is possible in the cycle after the return to IDLE.

Test Plan:
- Fetch only, addr 0xBFC00000, arready and rvalid immediate, rdata 0x3C1D0000 → arvalid at cycle 1, inst_addr_ok at cycle 1, inst_data_ok with inst_rdata=0x3C1D0000 at cycle 2.
- Both requests at reset exit → data served first (last_grant=INST), then fetch. A repeated simultaneous pair alternates inst and data.
- Store sb to 0x80000003, wstrb=4'b1000: wready 3 cycles before awready → data_addr_ok only on the awready cycle. awsize=0. bvalid after 2 cycles → data_data_ok for one cycle.
- Load lw while inst_req is held, rvalid delayed 5 cycles → inst_addr_ok stays 0 until the load's data_ok. The fetch is granted the next cycle.
- Change inst_addr after grant, before arready → araddr keeps the latched value.
- Assert rst during RD_DATA → all outputs 0 that cycle, state IDLE, no data_ok pulse.
